// File: rtl/am_mod_if.sv
// AM modulator sample-stream interface: audio/control toward the modulator, I/Q back.
interface am_mod_if #(
    parameter int DATA_SIZE  = 16,
    parameter int PHASE_BITS = 24
);
    logic                         strobe_in;
    logic signed [DATA_SIZE-1:0]  audio_in;
    logic        [DATA_SIZE-1:0]  mod_index;
    logic        [DATA_SIZE-2:0]  carrier_level;
    logic        [PHASE_BITS-1:0] phase_inc;
    logic                         strobe_out;
    logic signed [DATA_SIZE-1:0]  i_out;
    logic signed [DATA_SIZE-1:0]  q_out;

    modport master (
        output strobe_in, audio_in, mod_index, carrier_level, phase_inc,
        input  strobe_out, i_out, q_out
    );

    modport slave (
        input  strobe_in, audio_in, mod_index, carrier_level, phase_inc,
        output strobe_out, i_out, q_out
    );
endinterface

// File: rtl/am_mod.sv
// AM modulator: clamped envelope times quarter-wave-LUT NCO, 4-stage strobe pipeline.
// Optional AM_MOD_CLIP_CNT_EN adds a saturating clip_count of envelope clamp events.
module am_mod #(
    parameter int DATA_SIZE  = 16,
    parameter int PHASE_BITS = 24,
    parameter int LUT_BITS   = 8
) (
    input  logic      clk,
    input  logic      reset,
    am_mod_if.slave   bus
`ifdef AM_MOD_CLIP_CNT_EN
    ,
    output logic [15:0] clip_count
`endif
);
    localparam int PW        = 2*DATA_SIZE + 1;
    localparam int MW        = 2*DATA_SIZE;
    localparam int PH_W      = LUT_BITS + 2;
    localparam int ENV_W     = DATA_SIZE + 3;
    localparam int LUT_DEPTH = 2**LUT_BITS;

    localparam logic signed [ENV_W-1:0] ENV_MAX = ENV_W'((2**(DATA_SIZE-1)) - 1);
    localparam logic signed [MW:0]      RND     = (MW+1)'(2**(DATA_SIZE-2));
    localparam logic signed [MW:0]      SAT_MAX = (MW+1)'((2**(DATA_SIZE-1)) - 1);
    localparam logic signed [MW:0]      SAT_MIN = -((MW+1)'(2**(DATA_SIZE-1)));

    // Elaboration-time sine via Taylor series so the table needs no external generator.
    function automatic logic [DATA_SIZE-1:0] lut_entry(input int unsigned k);
        real x, term, acc;
        x    = 3.14159265358979323846 / 2.0 * (real'(k) + 0.5) / real'(LUT_DEPTH);
        term = x;
        acc  = x;
        for (int unsigned n = 1; n < 12; n++) begin
            term = -term * x * x / real'((2*n) * (2*n + 1));
            acc  = acc + term;
        end
        return DATA_SIZE'($rtoi(acc * real'((2**(DATA_SIZE-1)) - 1) + 0.5));
    endfunction

    function automatic logic signed [DATA_SIZE-1:0] round_sat(input logic signed [MW-1:0] p);
        logic signed [MW:0] r;
        r = ($signed({p[MW-1], p}) + RND) >>> (DATA_SIZE-1);
        if (r > SAT_MAX)      return {1'b0, {(DATA_SIZE-1){1'b1}}};
        else if (r < SAT_MIN) return {1'b1, {(DATA_SIZE-1){1'b0}}};
        else                  return $signed(r[DATA_SIZE-1:0]);
    endfunction

    logic [DATA_SIZE-1:0] lut [LUT_DEPTH];
    for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_lut
        localparam logic [DATA_SIZE-1:0] ENTRY = lut_entry(k);
        assign lut[k] = ENTRY;
    end

    logic [3:0]                  stb_q;
    logic [PHASE_BITS-1:0]       acc_q;
    logic signed [PW-1:0]        prod_q;
    logic [PH_W-1:0]             ph_q;
    logic [DATA_SIZE-2:0]        car_q;
    logic [DATA_SIZE-2:0]        env_q, env_d;
    logic signed [DATA_SIZE-1:0] sin_q, sin_d, cos_q, cos_d;
    logic signed [MW-1:0]        iprod_q, qprod_q;
    logic signed [DATA_SIZE-1:0] i_q, q_q;

    logic signed [ENV_W-1:0]     env_sum;
    logic [1:0]                  quad, cquad;
    logic [LUT_BITS-1:0]         idx;
    logic signed [DATA_SIZE-1:0] mag_s, mag_c;

    always_comb begin
        env_sum = $signed(ENV_W'(prod_q >>> (DATA_SIZE-1)))
                + $signed({{(ENV_W-DATA_SIZE+1){1'b0}}, car_q});
        if (env_sum < 0)            env_d = '0;
        else if (env_sum > ENV_MAX) env_d = '1;
        else                        env_d = env_sum[DATA_SIZE-2:0];

        quad  = ph_q[PH_W-1 -: 2];
        cquad = quad + 2'd1;
        idx   = ph_q[LUT_BITS-1:0];
        mag_s = $signed(quad[0]  ? lut[~idx] : lut[idx]);
        mag_c = $signed(cquad[0] ? lut[~idx] : lut[idx]);
        sin_d = quad[1]  ? -mag_s : mag_s;
        cos_d = cquad[1] ? -mag_c : mag_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stb_q   <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
            ph_q    <= '0;
            car_q   <= '0;
            env_q   <= '0;
            sin_q   <= '0;
            cos_q   <= '0;
            iprod_q <= '0;
            qprod_q <= '0;
            i_q     <= '0;
            q_q     <= '0;
        end else begin
            stb_q <= {stb_q[2:0], bus.strobe_in};
            if (bus.strobe_in) begin
                prod_q <= $signed(bus.audio_in) * $signed({1'b0, bus.mod_index});
                ph_q   <= acc_q[PHASE_BITS-1 -: PH_W];
                car_q  <= bus.carrier_level;
                acc_q  <= acc_q + bus.phase_inc;
            end
            if (stb_q[0]) begin
                env_q <= env_d;
                sin_q <= sin_d;
                cos_q <= cos_d;
            end
            if (stb_q[1]) begin
                iprod_q <= $signed({1'b0, env_q}) * cos_q;
                qprod_q <= $signed({1'b0, env_q}) * sin_q;
            end
            if (stb_q[2]) begin
                i_q <= round_sat(iprod_q);
                q_q <= round_sat(qprod_q);
            end
        end
    end

    assign bus.strobe_out = stb_q[3];
    assign bus.i_out      = i_q;
    assign bus.q_out      = q_q;

`ifdef AM_MOD_CLIP_CNT_EN
    logic [15:0] clip_q;
    logic        clip_d;

    assign clip_d = (env_sum < 0) || (env_sum > ENV_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            clip_q <= '0;
        end else if (stb_q[0] && clip_d && (clip_q != 16'hFFFF)) begin
            clip_q <= clip_q + 16'd1;
        end
    end

    assign clip_count = clip_q;
`endif
endmodule
